// File: rtl/spiker_frame_loader.sv
// -----------------------------------------------------------------------------
// spiker_frame_loader
//
// Upstream stage of the spike reader path. Collects a spike frame arriving as
// a stream of WIDTH-bit words (valid/ready) into one N_SPIKES-wide vector and
// presents it to the spike reader (valid/ready). The frame is held stable
// until the reader consumes it. A frame whose last-word marker does not line
// up with the final slot is dropped and flagged with a one-cycle err_o pulse.
//
// Optional feature (macro SPIKER_FRAME_LOADER_POPCOUNT_EN):
//   defined   - spike_count_o carries the number of set spikes in the frame
//   undefined - spike_count_o is tied to zero, no popcount logic is built
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   word_valid_i   input word valid
//   word_ready_o   loader can accept a word (registered)
//   word_data_i    spike word; bit j of word k is spike k*WIDTH+j
//   word_last_i    marks the final word of a frame
//   frame_o        assembled frame
//   frame_valid_o  frame_o holds a complete frame
//   frame_ready_i  reader consumes the frame
//   err_o          one-cycle pulse on a frame-length error
//   spike_count_o  number of set bits in frame_o
// -----------------------------------------------------------------------------
module spiker_frame_loader #(
    parameter  int WIDTH    = 32,
    parameter  int N_SPIKES = 784,
    localparam int N_WORDS  = (N_SPIKES + WIDTH - 1) / WIDTH,
    localparam int CNT_W    = $clog2(N_SPIKES + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                word_valid_i,
    output logic                word_ready_o,
    input  logic [WIDTH-1:0]    word_data_i,
    input  logic                word_last_i,
    output logic [N_SPIKES-1:0] frame_o,
    output logic                frame_valid_o,
    input  logic                frame_ready_i,
    output logic                err_o,
    output logic [CNT_W-1:0]    spike_count_o
);

    localparam int             WC_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(N_WORDS - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]          state_r;
    logic                word_ready_r;
    logic                err_r;
    logic [WC_W-1:0]     word_cnt_r;
    logic [N_SPIKES-1:0] frame_r;

    logic accept_s;
    logic last_slot_s;
    logic len_err_s;
    logic write_s;
    logic done_s;
    logic release_s;

    // Handshake decode: a word is good only if its last marker matches the slot.
    always_comb begin
        accept_s    = word_valid_i && word_ready_r;
        last_slot_s = (word_cnt_r == LAST_IDX);
        len_err_s   = accept_s && (word_last_i != last_slot_s);
        write_s     = accept_s && !len_err_s;
        done_s      = write_s && last_slot_s;
        release_s   = (state_r == ST_HOLD) && frame_ready_i;
    end

    // FILL/HOLD control, slot counter, ready and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_FILL;
            word_ready_r <= 1'b0;
            err_r        <= 1'b0;
            word_cnt_r   <= '0;
        end else begin
            err_r <= len_err_s;
            case (state_r)
                ST_FILL: begin
                    // Ready rises the cycle after reset and drops after the final word.
                    word_ready_r <= !done_s;
                    if (done_s) begin
                        state_r    <= ST_HOLD;
                        word_cnt_r <= '0;
                    end else if (len_err_s) begin
                        word_cnt_r <= '0;
                    end else if (write_s) begin
                        word_cnt_r <= word_cnt_r + {{(WC_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_HOLD: begin
                    word_ready_r <= release_s;
                    word_cnt_r   <= '0;
                    if (release_s) begin
                        state_r <= ST_FILL;
                    end
                end
                default: begin
                    state_r      <= ST_FILL;
                    word_ready_r <= 1'b0;
                    word_cnt_r   <= '0;
                end
            endcase
        end
    end

    // Frame assembly: each spike bit is loaded when its word's slot is written.
    // Bits of the last word beyond N_SPIKES have no storage and are discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_r <= '0;
        end else if (write_s) begin
            for (int i = 0; i < N_SPIKES; i++) begin
                if (word_cnt_r == WC_W'(i / WIDTH)) begin
                    frame_r[i] <= word_data_i[i % WIDTH];
                end
            end
        end
    end

`ifdef SPIKER_FRAME_LOADER_POPCOUNT_EN
    localparam int               LAST_BITS = N_SPIKES - (N_WORDS - 1) * WIDTH;
    localparam logic [WIDTH-1:0] LAST_MASK = {WIDTH{1'b1}} >> (WIDTH - LAST_BITS);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] word_pop_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] w);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < WIDTH; j++) begin
            acc = acc + CNT_W'(w[j]);
        end
        return acc;
    endfunction

    // Popcount of the incoming word, masked to valid spikes on the last slot.
    always_comb begin
        if (last_slot_s) begin
            word_pop_s = popcount(word_data_i & LAST_MASK);
        end else begin
            word_pop_s = popcount(word_data_i);
        end
    end

    // Spike count accumulator: restarts on slot 0, cleared on a length error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= '0;
        end else if (len_err_s) begin
            count_r <= '0;
        end else if (write_s) begin
            if (word_cnt_r == '0) begin
                count_r <= word_pop_s;
            end else begin
                count_r <= count_r + word_pop_s;
            end
        end
    end

    assign spike_count_o = count_r;
`else
    assign spike_count_o = {CNT_W{1'b0}};
`endif

    assign word_ready_o  = word_ready_r;
    assign frame_valid_o = (state_r == ST_HOLD);
    assign err_o         = err_r;
    assign frame_o       = frame_r;

endmodule

// File: tb/tb_spiker_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_spiker_frame_loader
//
// Self-checking bench for spiker_frame_loader at default parameters. A
// transaction-level reference model (queue of accepted words, frame built
// from the queue on completion, $countones for the spike count) predicts
// ready/valid/err every cycle and the frame/count whenever they are defined.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_spiker_frame_loader;

    localparam int WIDTH    = 32;
    localparam int N_SPIKES = 784;
    localparam int N_WORDS  = 25;
    localparam int CNT_W    = 10;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                word_valid_i;
    logic                word_ready_o;
    logic [WIDTH-1:0]    word_data_i;
    logic                word_last_i;
    logic [N_SPIKES-1:0] frame_o;
    logic                frame_valid_o;
    logic                frame_ready_i;
    logic                err_o;
    logic [CNT_W-1:0]    spike_count_o;

    spiker_frame_loader #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .word_valid_i  (word_valid_i),
        .word_ready_o  (word_ready_o),
        .word_data_i   (word_data_i),
        .word_last_i   (word_last_i),
        .frame_o       (frame_o),
        .frame_valid_o (frame_valid_o),
        .frame_ready_i (frame_ready_i),
        .err_o         (err_o),
        .spike_count_o (spike_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic                exp_ready;
    logic                exp_valid;
    logic                exp_err;
    logic [N_SPIKES-1:0] exp_frame;
    logic [CNT_W-1:0]    exp_count;
    logic                chk_frame;
    logic                chk_count;
    logic [WIDTH-1:0]    words_q[$];

    task automatic check_eq(input string tag, input logic [N_SPIKES-1:0] obs,
                            input logic [N_SPIKES-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] model_count(input logic [N_SPIKES-1:0] f);
`ifdef SPIKER_FRAME_LOADER_POPCOUNT_EN
        return CNT_W'($countones(f));
`else
        return {CNT_W{1'b0}};
`endif
    endfunction

    task automatic model_reset();
        exp_ready = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_frame = '0;
        exp_count = '0;
        chk_frame = 1'b1;
        chk_count = 1'b1;
        words_q.delete();
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic rst, input logic vld, input logic [WIDTH-1:0] dat,
                         input logic lst, input logic frdy);
        logic old_ready;
        rst_i         = rst;
        word_valid_i  = vld;
        word_data_i   = dat;
        word_last_i   = lst;
        frame_ready_i = frdy;
        @(negedge clk_i);
        check_eq("word_ready",  N_SPIKES'(word_ready_o),  N_SPIKES'(exp_ready));
        check_eq("frame_valid", N_SPIKES'(frame_valid_o), N_SPIKES'(exp_valid));
        check_eq("err",         N_SPIKES'(err_o),         N_SPIKES'(exp_err));
        if (chk_frame) check_eq("frame", frame_o, exp_frame);
        if (chk_count) check_eq("spike_count", N_SPIKES'(spike_count_o), N_SPIKES'(exp_count));

        old_ready = exp_ready;
        if (rst) begin
            model_reset();
        end else begin
            exp_err = 1'b0;
            if (exp_valid) begin
                if (frdy) begin
                    exp_valid = 1'b0;
                    exp_ready = 1'b1;
                end
            end else begin
                exp_ready = 1'b1;
                if (vld && old_ready) begin
                    if (lst != (words_q.size() == N_WORDS - 1)) begin
                        exp_err   = 1'b1;
                        exp_count = '0;
                        chk_frame = 1'b0;
                        chk_count = 1'b1;
                        words_q.delete();
                    end else begin
                        words_q.push_back(dat);
                        chk_frame = 1'b0;
                        chk_count = 1'b0;
                        if (lst) begin
                            exp_frame = '0;
                            for (int k = 0; k < words_q.size(); k++)
                                for (int j = 0; j < WIDTH; j++)
                                    if (k * WIDTH + j < N_SPIKES)
                                        exp_frame[k * WIDTH + j] = words_q[k][j];
                            exp_count = model_count(exp_frame);
                            exp_valid = 1'b1;
                            exp_ready = 1'b0;
                            chk_frame = 1'b1;
                            chk_count = 1'b1;
                            words_q.delete();
                        end
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Offer a word until the model says it was accepted (bounded).
    task automatic send_word(input logic [WIDTH-1:0] dat, input logic lst);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
            acc = exp_ready;
            cycle(1'b0, 1'b1, dat, lst, 1'b1);
        end
        check_eq("send_accepted", N_SPIKES'(acc), N_SPIKES'(1'b1));
    endtask

    task automatic idle(input int n, input logic frdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, $urandom_range(1, 0), frdy);
    endtask

    task automatic good_frame_random();
        for (int k = 0; k < N_WORDS; k++) send_word($urandom, (k == N_WORDS - 1));
    endtask

    initial begin
        rst_i = 1'b1; word_valid_i = 1'b0; word_data_i = '0;
        word_last_i = 1'b0; frame_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        // Reset release: ready low in release cycle, high on the next
        idle(3, 1'b0);

        // All-ones frame, then holdoff with frame_ready low for 10 cycles
        for (int k = 0; k < N_WORDS; k++) send_word(32'hFFFF_FFFF, (k == N_WORDS - 1));
        idle(10, 1'b0);
        idle(2, 1'b1);

        // One-hot walking frame, handshake immediately
        for (int k = 0; k < N_WORDS; k++) send_word(32'h0000_0001 << (k % 32), (k == N_WORDS - 1));
        idle(3, 1'b1);

        // Early last on word 10, then a correct frame
        for (int k = 0; k <= 10; k++) send_word($urandom, (k == 10));
        idle(2, 1'b0);
        good_frame_random();
        idle(2, 1'b1);

        // 25 words without last, then 25 more words forming a good frame
        for (int k = 0; k < N_WORDS; k++) send_word($urandom, 1'b0);
        good_frame_random();
        idle(2, 1'b1);

        // Reset mid-fill at word 12, then a fresh frame
        for (int k = 0; k < 12; k++) send_word(32'hFFFF_FFFF, 1'b0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1, 1'b0);
        for (int k = 0; k < N_WORDS; k++) send_word($urandom & 32'h0F0F_0F0F, (k == N_WORDS - 1));
        idle(2, 1'b1);

        // Randomized traffic: mostly legal framing, occasional bad last and reset
        for (int i = 0; i < 4000; i++) begin
            logic lst;
            lst = (words_q.size() == N_WORDS - 1);
            if ($urandom_range(99, 0) < 4) lst = !lst;
            cycle(($urandom_range(999, 0) < 3), ($urandom_range(99, 0) < 75), $urandom,
                  lst, ($urandom_range(99, 0) < 35));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
